// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB slave holding NUM_REGS registers of DATA_WIDTH bits,
// with WAIT_CYCLES programmable wait states and an error response for word
// indices beyond the register file. Contents are exported flat on regs_o.
// Optional feature macro: APB_PSTRB_EN adds the pstrb port and byte-lane writes.
module apb_regfile_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                           pclk,
   input  logic                           preset,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
`endif
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pready,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int OFF_BITS = $clog2(BYTES);
   localparam int IDX_W    = ADDR_WIDTH - OFF_BITS;
   localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

   state_t                                  state, state_n;
   logic [3:0]                              cnt, cnt_n;
   logic                                    capture, commit;
   logic [IDX_W-1:0]                        idx;
   logic                                    wr;
   logic [DATA_WIDTH-1:0]                   wdata;
`ifdef APB_PSTRB_EN
   logic [BYTES-1:0]                        strb;
`endif
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]     regs;
   logic                                    in_range;
   logic [SEL_W-1:0]                        sel;

   assign in_range = (idx < IDX_W'(NUM_REGS));
   assign sel      = idx[SEL_W-1:0];

   // Byte-offset address bits never select anything.
   generate
      if (OFF_BITS > 0) begin : g_off
         logic unused_offset;
         assign unused_offset = ^paddr[OFF_BITS-1:0];
      end
   endgenerate

   // Next-state logic: setup capture, wait countdown, completion and master abort.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
      state_n = state;
      cnt_n   = cnt;
      capture = 1'b0;
      commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               capture = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_n = ST_WAIT;
                  cnt_n   = CNT_INIT;
               end else begin
                  state_n = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               state_n = ST_IDLE;
            end else if (cnt == 4'd0) begin
               state_n = ST_ACCESS;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         ST_ACCESS: begin
            state_n = ST_IDLE;
            commit  = psel && wr && in_range;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State, wait counter and setup-phase capture registers.
   always_ff @(posedge pclk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (preset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         idx   <= '0;
         wr    <= 1'b0;
         wdata <= '0;
`ifdef APB_PSTRB_EN
         strb  <= '0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (capture) begin
            idx   <= paddr[ADDR_WIDTH-1:OFF_BITS];
            wr    <= pwrite;
            wdata <= pwdata;
`ifdef APB_PSTRB_EN
            strb  <= pstrb;
`endif
         end
      end
   end

   // Register file update on a completing in-range write.
   always_ff @(posedge pclk) begin
      // NOTE: the register file is built from flops, so it is cleared by reset like any other state.
      if (preset) begin
         regs <= '0;
      end else if (commit) begin
`ifdef APB_PSTRB_EN
         for (int b = 0; b < BYTES; b++) begin
            if (strb[b]) regs[sel][b*8 +: 8] <= wdata[b*8 +: 8];
         end
`else
         regs[sel] <= wdata;
`endif
      end
   end

   assign pready  = (state == ST_ACCESS);
   assign pslverr = pready && !in_range;
   assign prdata  = (pready && !wr && in_range) ? regs[sel] : '0;
   assign regs_o  = regs;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: drives two slaves (no wait states and WAIT_CYCLES=3)
// sharing one bus, and checks every transfer against an array model of the
// register file built from the bus rules.
module tb_apb_regfile_slave;

   localparam int NREG   = 8;
   localparam int W_SLOW = 3;

   logic         pclk = 1'b0;
   logic         preset, penable, pwrite;
   logic         psel_a, psel_b;
   logic [31:0]  paddr, pwdata;
   logic [3:0]   pstrb;
   logic [31:0]  prdata_a, prdata_b;
   logic         pready_a, pready_b, pslverr_a, pslverr_b;
   logic [255:0] regs_a, regs_b;

   logic [31:0]  model [2][NREG];
   int           passes = 0;
   int           total  = 0;

   always #5 pclk = ~pclk;

   apb_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .WAIT_CYCLES(0)) dut_a (
      .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a), .regs_o(regs_a)
   );

   apb_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .WAIT_CYCLES(W_SLOW)) dut_b (
      .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b), .regs_o(regs_b)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic get_ready(input int d);
      return (d == 0) ? pready_a : pready_b;
   endfunction

   function automatic logic get_err(input int d);
      return (d == 0) ? pslverr_a : pslverr_b;
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      return (d == 0) ? prdata_a : prdata_b;
   endfunction

   function automatic logic [255:0] get_regs(input int d);
      return (d == 0) ? regs_a : regs_b;
   endfunction

   function automatic logic [255:0] model_flat(input int d);
      logic [255:0] r;
      for (int i = 0; i < NREG; i++) r[i*32 +: 32] = model[d][i];
      return r;
   endfunction

   task automatic set_sel(input int d, input logic v);
      if (d == 0) psel_a = v;
      else        psel_b = v;
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NREG; i++) model[d][i] = 32'h0;
   endtask

   // One complete transfer; entered and left at posedge+1 so transfers can run back to back.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input string tag, output logic [31:0] rd);
      int          idx, cycles, expc;
      logic        err;
      bit          done;
      logic [3:0]  eff;
      logic [31:0] exp_rd;
      idx    = int'(addr >> 2);
      expc   = (d == 0) ? 2 : 2 + W_SLOW;
      exp_rd = (idx < NREG) ? model[d][idx] : 32'h0;
      eff    = strb;
`ifndef APB_PSTRB_EN
      eff    = 4'hF;
`endif
      rd     = 32'h0;
      err    = 1'b0;
      set_sel(d, 1'b1);
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      // Access-phase bus values are garbage; only setup values may be used.
      penable = 1'b1; pwrite = ~wr; paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
      cycles = 1;
      done   = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge pclk);
         cycles++;
         if (get_ready(d)) begin
            rd   = get_rdata(d);
            err  = get_err(d);
            done = 1'b1;
         end else begin
            check({tag, "_err_while_wait"}, get_err(d), 1'b0);
            @(posedge pclk); #1;
         end
      end
      if (!done) begin
         check({tag, "_timeout_pready"}, get_ready(d), 1'b1);
      end else begin
         check({tag, "_cycles"}, cycles, expc);
         check({tag, "_pslverr"}, err, (idx >= NREG));
         check({tag, "_prdata"}, rd, wr ? 32'h0 : exp_rd);
      end
      @(posedge pclk); #1;
      set_sel(d, 1'b0);
      penable = 1'b0;
      if (done && wr && idx < NREG)
         for (int b = 0; b < 4; b++)
            if (eff[b]) model[d][idx][b*8 +: 8] = data[b*8 +: 8];
      check({tag, "_regs_o"}, get_regs(d), model_flat(d));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          d;
      bit          wr;
      logic [31:0] addr;

      preset = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      clear_model();
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_pready_a", pready_a, 1'b0);
      check("rst_pslverr_a", pslverr_a, 1'b0);
      check("rst_prdata_a", prdata_a, 32'h0);
      check("rst_regs_a", regs_a, 256'h0);
      check("rst_pready_b", pready_b, 1'b0);
      check("rst_regs_b", regs_b, 256'h0);
      @(posedge pclk); #1;
      preset = 1'b0;

      // Every index reads zero after reset, two cycles each, back to back.
      for (int i = 0; i < NREG; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'hF, "rd_reset", rd);

      // Basic write/read of register 2.
      xfer(0, 1'b1, 32'h8, 32'hA5A5_1234, 4'hF, "wr_08", rd);
      xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, "rd_08", rd);
      check("rd_08_value", rd, 32'hA5A5_1234);
      check("reg2_slice", regs_a[95:64], 32'hA5A5_1234);

      // Out-of-range write then read.
      xfer(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, "wr_oob", rd);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, "rd_oob", rd);

      // psel with penable in IDLE is ignored.
      psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge pclk);
         check("proto_viol_pready", pready_a, 1'b0);
         @(posedge pclk); #1;
      end
      psel_a = 1'b0; penable = 1'b0;
      check("proto_viol_regs", regs_a, model_flat(0));

      // Wait-state slave: five-cycle transfers.
      xfer(1, 1'b1, 32'h14, 32'h0BAD_CAFE, 4'hF, "slow_wr", rd);
      xfer(1, 1'b0, 32'h14, 32'h0, 4'hF, "slow_rd", rd);
      check("slow_rd_value", rd, 32'h0BAD_CAFE);
      xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, "slow_rd_oob", rd);

`ifdef APB_PSTRB_EN
      xfer(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, "strb_init", rd);
      xfer(0, 1'b1, 32'h1, 32'hAABB_CCDD, 4'b0101, "strb_wr", rd);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, "strb_rd", rd);
      check("strb_merge", rd, 32'h11BB_33DD);
      xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, "strb_zero", rd);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "strb_zero_rd", rd);
      check("strb_zero_value", rd, 32'h11BB_33DD);
`endif

      // Randomised traffic on both slaves, including out-of-range words.
      for (int n = 0; n < 40; n++) begin
         d    = int'($urandom_range(0, 1));
         wr   = 1'($urandom);
         addr = 32'($urandom_range(0, 39));
         xfer(d, wr, addr, $urandom, 4'($urandom), "rand", rd);
      end

      // Master abort during WAIT: write to word 1 must not happen.
      xfer(1, 1'b1, 32'h4, 32'h1357_9BDF, 4'hF, "abort_pre", rd);
      psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hFFFF_0000; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel_b = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("abort_pready", pready_b, 1'b0);
      @(posedge pclk); #1;
      check("abort_regs", regs_b, model_flat(1));
      xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, "abort_rd", rd);
      check("abort_rd_value", rd, 32'h1357_9BDF);

      // Reset during WAIT: in-flight write lost, everything clears.
      psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h2468_ACE0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b0;
      clear_model();
      @(negedge pclk);
      check("midrst_pready", pready_b, 1'b0);
      check("midrst_pslverr", pslverr_b, 1'b0);
      check("midrst_regs_a", regs_a, 256'h0);
      check("midrst_regs_b", regs_b, 256'h0);
      @(negedge pclk);
      check("midrst_pready_hold", pready_b, 1'b0);
      @(posedge pclk); #1;
      psel_b = 1'b0; penable = 1'b0;
      xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, "post_rst_rd", rd);
      xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, "post_rst_rd_a", rd);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
